putbits_writer: RTL and testbench
=================================

Name: putbits_writer

Overview:
- Bitstream writer for the MPEG encoder path; the write-side counterpart of the flush/refill bitstream reader.
- Accepts variable-length codes of 0..32 bits each and packs them MSB-first into a contiguous byte stream.
- Emits bytes over a valid/ready interface toward the output byte buffer.
- On flush, zero-pads to a byte boundary, drains all pending bytes, marks the final byte and pulses done.

Parameters:
ACC_BITS, 64, accumulator width in bits; fixed at 64, other values unsupported.
MAX_LEN, 32, maximum code length accepted per write.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset: 0 resets immediately, released synchronously
in_valid  in  1  code present on in_val/in_len
in_ready  out  1  writer can accept a code this cycle
in_val  in  32  code value, right-justified; bits at or above in_len ignored
in_len  in  6  code length; 0 = no-op; 33..63 treated as 32
flush  in  1  request byte-align and drain; sampled only in S_RUN
out_valid  out  1  out_byte holds a valid byte
out_ready  in  1  downstream accepts byte
out_byte  out  8  next stream byte, MSB = earliest bit
out_last  out  1  qualifies out_byte as the final byte of a flush
done  out  1  one-cycle pulse when a flush completes
byte_count  out  32  total bytes handed off since reset, wraps modulo 2^32

Behaviour:
- Internal state:
  - acc[63:0]: pending bits, left-justified (acc[63] is the oldest bit).
  - cnt: 0..64, number of pending bits.
  - state.
- Reset: acc=0, cnt=0, state=S_RUN, byte_count=0, done=0. in_ready=1, out_valid=0, out_last=0.
- in_ready = (state==S_RUN) && (cnt<=32).
- out_valid = (cnt>=8) || (state==S_DRAIN && cnt>0).
- out_byte = acc[63:56].
- out_last = (state==S_DRAIN) && (cnt==8).
- emit = out_valid && out_ready. On emit: acc <<= 8, cnt -= 8, byte_count += 1.
- accept = in_valid && in_ready.
  - L = min(in_len, 32); v = in_val & ((1<<L)-1).
  - v is ORed into acc at bit positions [63-c' -: L], where c' = cnt-8 if emit this cycle, else cnt.
  - cnt_next = c' + L.
  - accept and emit in the same cycle are both honoured with no bit loss.
- Latency: a byte completed by an accept is visible on out_byte the next cycle.
- A byte held with out_ready=0 stays stable (out_byte, out_last unchanged) until taken.
- States:
  - S_RUN: on flush=1, go to S_ALIGN. If in_valid is also accepted that cycle, the code is packed first and the flush covers it.
  - S_ALIGN (1 cycle): cnt rounded up to the next multiple of 8; padding bits in acc are already 0. in_ready=0. Emits allowed. Then go to S_DRAIN.
  - S_DRAIN: in_ready=0. Emit until cnt==0, then go to S_DONE.
  - S_DONE (1 cycle): done=1, then return to S_RUN.
- Flush with cnt==0: no bytes emitted, out_last never asserted, done pulses 2 cycles after flush is sampled.
- flush outside S_RUN is ignored.
- in_len==0 with in_valid: accepted, no state change.
- Reset asserted mid-operation, including mid-drain: all pending bits are discarded and state returns to reset values.
- Arithmetic: cnt is 7 bits; shifts are computed on 64-bit values, with no truncation before masking.

Decomposition:
- Package mpeg_bits_pkg holds:
  - state encoding S_RUN/S_ALIGN/S_DRAIN/S_DONE (2-bit);
  - ACC_BITS and MAX_LEN constants;
  - a length-to-mask function, shareable with the reader side.
- No sub-module; single module with one registered always block plus combinational outputs.

Test Plan:
- Reset, then release with no stimulus -> in_ready=1, out_valid=0, byte_count=0, done=0.
- Write (0x1,len4), then (0x2,len4), out_ready=1 -> single byte 0x12, byte_count=1, out_last=0.
- Write (0x000001B3,len32) -> bytes 00,00,01,B3 in order on consecutive handshakes; byte_count=4.
- Write (0xFFFFFFFF,len1), then (0x0,len7) -> byte 0x80, proving bits above len are masked.
- Write (0x5,len3), then flush -> byte 0xA0 with out_last=1; done pulses one cycle after the last handshake; then back in S_RUN with in_ready=1.
- Hold out_ready=0 and write (0xDEADBEEF,32) then (0x01234567,32) -> in_ready drops to 0 at cnt=64. Release out_ready -> DE AD BE EF 01 23 45 67. Repeat with rst pulsed low mid-drain -> out_valid=0 immediately, cnt=0, byte_count=0.

Source files
------------

// File: rtl/mpeg_bits_pkg.sv
// Shared definitions for the MPEG bitstream reader/writer pair:
// writer state encoding, accumulator geometry and the code-length mask helper.
package mpeg_bits_pkg;

    localparam int ACC_BITS = 64;
    localparam int MAX_LEN  = 32;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_ALIGN = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } wr_state_e;

    // Mask with the low 'len' bits set; lengths of 32 and above give all ones.
    function automatic logic [31:0] len_mask(input logic [5:0] len);
        logic [63:0] wide_mask;
        wide_mask = (64'd1 << len) - 64'd1;
        if (len >= 6'd32) begin
            len_mask = 32'hFFFF_FFFF;
        end else begin
            len_mask = wide_mask[31:0];
        end
    endfunction

endpackage

// File: rtl/putbits_writer.sv
// MSB-first variable-length code packer: codes of 0..32 bits go into a 64-bit
// left-justified accumulator and leave as bytes over a valid/ready interface.
import mpeg_bits_pkg::*;

module putbits_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_val,
    input  logic [5:0]  in_len,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        done,
    output logic [31:0] byte_count
);

    wr_state_e   state_r, state_nxt_s;
    logic [63:0] acc_r, acc_nxt_s;
    logic [6:0]  cnt_r, cnt_nxt_s;
    logic [31:0] byte_count_r;

    logic        emit_s;
    logic        accept_s;
    logic [5:0]  len_s;
    logic [63:0] code_s;
    logic [63:0] base_acc_s;
    logic [6:0]  base_cnt_s;
    logic [6:0]  shamt_s;
    logic [6:0]  aligned_cnt_s;

    // Handshake and byte-output decode from the registered state.
    always_comb begin
        in_ready   = (state_r == S_RUN) && (cnt_r <= 7'd32);
        out_valid  = (cnt_r >= 7'd8) || ((state_r == S_DRAIN) && (cnt_r != 7'd0));
        out_byte   = acc_r[63:56];
        out_last   = (state_r == S_DRAIN) && (cnt_r == 7'd8);
        done       = (state_r == S_DONE);
        byte_count = byte_count_r;
        emit_s     = out_valid && out_ready;
        accept_s   = in_valid && in_ready;
    end

    // Packing datapath and next-state selection.
    always_comb begin
        len_s  = (in_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : in_len;
        code_s = {32'd0, in_val & len_mask(len_s)};

        // A byte leaving this cycle frees its 8 bits before the new code lands.
        if (emit_s) begin
            base_acc_s = acc_r << 8;
            base_cnt_s = cnt_r - 7'd8;
        end else begin
            base_acc_s = acc_r;
            base_cnt_s = cnt_r;
        end

        shamt_s       = 7'd64 - base_cnt_s - {1'b0, len_s};
        aligned_cnt_s = (base_cnt_s + 7'd7) & 7'h78;

        acc_nxt_s   = base_acc_s;
        cnt_nxt_s   = base_cnt_s;
        state_nxt_s = state_r;

        case (state_r)
            S_RUN: begin
                if (accept_s) begin
                    acc_nxt_s = base_acc_s | (code_s << shamt_s);
                    cnt_nxt_s = base_cnt_s + {1'b0, len_s};
                end else begin
                    cnt_nxt_s = base_cnt_s;
                end
                if (flush) begin
                    state_nxt_s = S_ALIGN;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_ALIGN: begin
                // Padding bits are already zero, so alignment only moves cnt.
                cnt_nxt_s = aligned_cnt_s;
                if (aligned_cnt_s == 7'd0) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (base_cnt_s == 7'd0) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nxt_s = S_RUN;
            end
            default: begin
                state_nxt_s = S_RUN;
                acc_nxt_s   = 64'd0;
                cnt_nxt_s   = 7'd0;
            end
        endcase
    end

    // State, accumulator and byte counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_RUN;
            acc_r        <= 64'd0;
            cnt_r        <= 7'd0;
            byte_count_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (emit_s) begin
                byte_count_r <= byte_count_r + 32'd1;
            end else begin
                byte_count_r <= byte_count_r;
            end
        end
    end

endmodule

// File: tb/tb_putbits_writer.sv
// Directed bench for putbits_writer: a per-cycle vector table plus hand-written
// sequences for back-pressure at a full accumulator and reset during a drain.
module tb_putbits_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_val;
    logic [5:0]  in_len;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        done;
    logic [31:0] byte_count;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        iv;
        logic [31:0] val;
        logic [5:0]  len;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_byte;
        logic        e_last;
        logic        e_done;
        logic [31:0] e_bc;
    } vec_t;

    vec_t vq[$];

    putbits_writer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_val     (in_val),
        .in_len     (in_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .done       (done),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs for this cycle, then outputs expected during it (before its edge).
    task automatic v(input logic iv, input logic [31:0] val, input logic [5:0] len,
                     input logic fl, input logic ordy,
                     input logic ir, input logic ov, input logic [7:0] byt,
                     input logic last, input logic dn, input logic [31:0] bc);
        vq.push_back('{iv, val, len, fl, ordy, ir, ov, byt, last, dn, bc});
    endtask

    task automatic drive(input logic iv, input logic [31:0] val, input logic [5:0] len,
                         input logic fl, input logic ordy);
        in_valid  = iv;
        in_val    = val;
        in_len    = len;
        flush     = fl;
        out_ready = ordy;
    endtask

    logic [7:0] seq_bytes [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        drive(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);

        //  iv    val           len    fl    ordy  | ir    ov    byte   last  done  bc
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
        v(1'b1, 32'h1,        6'd4,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
        v(1'b1, 32'h2,        6'd4,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 32'd0);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd1);
        v(1'b1, 32'h000001B3, 6'd32, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd1);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'd1);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'd2);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 32'd3);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'hB3, 1'b0, 1'b0, 32'd4);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd5);
        // Bits above in_len are masked off.
        v(1'b1, 32'hFFFFFFFF, 6'd1,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd5);
        v(1'b1, 32'h0,        6'd7,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd5);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 32'd5);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd6);
        // 3-bit code then flush: RUN, ALIGN, DRAIN(last), DONE, RUN.
        v(1'b1, 32'h5,        6'd3,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd6);
        v(1'b0, 32'h0,        6'd0,  1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd6);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'd6);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 32'd6);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd7);
        // Flush with nothing pending: done two cycles after the flush.
        v(1'b0, 32'h0,        6'd0,  1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd7);
        // Code and flush together, with back-pressure holding bytes stable.
        v(1'b1, 32'h00000ABC, 6'd12, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b0,  1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b0,  1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 32'd7);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b0,  1'b0, 1'b1, 8'hC0, 1'b1, 1'b0, 32'd8);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b1, 8'hC0, 1'b1, 1'b0, 32'd8);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd9);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd9);
        // Zero-length write is a no-op; length 40 is clamped to 32.
        v(1'b1, 32'hFFFFFFFF, 6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd9);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd9);
        v(1'b1, 32'hFFFFFFFF, 6'd40, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd9);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b0,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd9);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd9);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd10);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd11);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd12);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd13);
        // Accept and emit in the same cycle lose no bits.
        v(1'b1, 32'h12345678, 6'd32, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd13);
        v(1'b1, 32'h0000009A, 6'd8,  1'b0, 1'b1,  1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 32'd13);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 32'd14);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h56, 1'b0, 1'b0, 32'd15);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 32'd16);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b1,  1'b1, 1'b1, 8'h9A, 1'b0, 1'b0, 32'd17);
        v(1'b0, 32'h0,        6'd0,  1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd18);

        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i),   {31'd0, in_ready},  {31'd0, vq[i].e_ir});
            chk($sformatf("v%0d out_valid", i),  {31'd0, out_valid}, {31'd0, vq[i].e_ov});
            chk($sformatf("v%0d out_last", i),   {31'd0, out_last},  {31'd0, vq[i].e_last});
            chk($sformatf("v%0d done", i),       {31'd0, done},      {31'd0, vq[i].e_done});
            chk($sformatf("v%0d byte_count", i), byte_count,         vq[i].e_bc);
            if (vq[i].e_ov) begin
                chk($sformatf("v%0d out_byte", i), {24'd0, out_byte}, {24'd0, vq[i].e_byte});
            end
            drive(vq[i].iv, vq[i].val, vq[i].len, vq[i].fl, vq[i].ordy);
        end

        seq_bytes[0] = 8'hDE; seq_bytes[1] = 8'hAD; seq_bytes[2] = 8'hBE; seq_bytes[3] = 8'hEF;
        seq_bytes[4] = 8'h01; seq_bytes[5] = 8'h23; seq_bytes[6] = 8'h45; seq_bytes[7] = 8'h67;

        // Fill the accumulator to 64 bits while downstream stalls, then drain.
        @(negedge clk);
        drive(1'b1, 32'hDEADBEEF, 6'd32, 1'b0, 1'b0);
        @(negedge clk);
        chk("full32 in_ready", {31'd0, in_ready}, 32'd1);
        chk("full32 out_byte", {24'd0, out_byte}, 32'h0000_00DE);
        drive(1'b1, 32'h01234567, 6'd32, 1'b0, 1'b0);
        @(negedge clk);
        chk("full64 in_ready", {31'd0, in_ready}, 32'd0);
        chk("full64 out_valid", {31'd0, out_valid}, 32'd1);
        chk("full64 out_byte", {24'd0, out_byte}, 32'h0000_00DE);
        drive(1'b0, 32'h0, 6'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("drain%0d out_byte", i), {24'd0, out_byte}, {24'd0, seq_bytes[i]});
            @(negedge clk);
        end
        chk("drained out_valid", {31'd0, out_valid}, 32'd0);
        chk("drained byte_count", byte_count, 32'd26);

        // Same fill, but reset lands in the middle of the drain.
        drive(1'b1, 32'hDEADBEEF, 6'd32, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h01234567, 6'd32, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 6'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pre_rst%0d out_byte", i), {24'd0, out_byte}, {24'd0, seq_bytes[i]});
            @(negedge clk);
        end
        chk("pre_rst byte_count", byte_count, 32'd29);
        #2 rst = 1'b0;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst byte_count", byte_count, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("post_rst out_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 32'h0000000F, 6'd4, 1'b1, 1'b1);
        @(negedge clk);
        chk("post_rst align in_ready", {31'd0, in_ready}, 32'd0);
        chk("post_rst align out_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 32'h0, 6'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst drain out_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst drain out_byte", {24'd0, out_byte}, 32'h0000_00F0);
        chk("post_rst drain out_last", {31'd0, out_last}, 32'd1);
        @(negedge clk);
        chk("post_rst done", {31'd0, done}, 32'd1);
        chk("post_rst byte_count", byte_count, 32'd1);
        @(negedge clk);
        chk("post_rst back in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst done cleared", {31'd0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
